// File: rtl/regfile_wb_decoder.sv
// regfile_wb_decoder
//   Buffers register write-back requests in a 2-entry FIFO and turns each
//   popped entry into a one-hot register write enable. Writes aimed at
//   register 0 are discarded and counted instead of being issued.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a write-back request is present
//   in_addr    : destination register index (W bits)
//   in_data    : write-back data (D bits)
//   in_ready   : the FIFO has room this cycle (registered state only)
//   stall      : when high, nothing is popped
//   we_out     : one-hot per-register write enable (2**W bits), one cycle wide
//   wdata_out  : data accompanying we_out, holds between writes
//   drop_cnt   : saturating count of dropped writes to register 0
//   wr_cnt     : wrapping count of performed register writes
//   fsm_active : debug view of the control state (0 = EMPTY, 1 = ACTIVE)
//
// Handshake: a request transfers on a rising edge where in_valid and in_ready
// are both high; in_valid may be asserted regardless of in_ready, and a
// request offered while in_ready is low is simply not taken. There is no
// bypass: a request is popped at the earliest on the edge after its push.
module regfile_wb_decoder #(
  parameter int W = 5,
  parameter int D = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [W-1:0]      in_addr,
  input  logic [D-1:0]      in_data,
  output logic              in_ready,
  input  logic              stall,
  output logic [2**W-1:0]   we_out,
  output logic [D-1:0]      wdata_out,
  output logic [7:0]        drop_cnt,
  output logic [15:0]       wr_cnt,
  output logic              fsm_active
);

  localparam int N = 2**W;

  typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [1:0]   count;
  logic         wr_ptr, rd_ptr;
  logic [W-1:0] addr_mem [2];
  logic [D-1:0] data_mem [2];

  logic         push, pop;
  logic [W-1:0] pop_addr;
  logic [D-1:0] pop_data;
  logic [N-1:0] one_hot;

  assign in_ready   = (count < 2'd2);
  assign push       = in_valid && in_ready;
  assign pop        = (count != 2'd0) && !stall;
  assign pop_addr   = addr_mem[rd_ptr];
  assign pop_data   = data_mem[rd_ptr];
  assign fsm_active = (state == ACTIVE);

  always_comb begin
    one_hot           = '0;
    one_hot[pop_addr] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:  if (push) state_nxt = ACTIVE;
      ACTIVE: if (pop && !push && count == 2'd1) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output stage: we_out is a one-cycle pulse, wdata_out only moves on a
  // real write so it holds across drops, stalls and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_out    <= '0;
      wdata_out <= '0;
      drop_cnt  <= 8'd0;
      wr_cnt    <= 16'd0;
    end else begin
      we_out <= '0;
      if (pop) begin
        if (pop_addr != '0) begin
          we_out    <= one_hot;
          wdata_out <= pop_data;
          wr_cnt    <= wr_cnt + 16'd1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_decoder.sv
module tb_regfile_wb_decoder;

  localparam int W = 5;
  localparam int D = 32;
  localparam int N = 2**W;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_addr = '0;
  logic [D-1:0] in_data = '0;
  logic         stall = 1'b0;
  logic         in_ready;
  logic [N-1:0] we_out;
  logic [D-1:0] wdata_out;
  logic [7:0]   drop_cnt;
  logic [15:0]  wr_cnt;
  logic         fsm_active;

  always #5 clk = ~clk;

  regfile_wb_decoder #(.W(W), .D(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stall      (stall),
    .we_out     (we_out),
    .wdata_out  (wdata_out),
    .drop_cnt   (drop_cnt),
    .wr_cnt     (wr_cnt),
    .fsm_active (fsm_active)
  );

  // ---------------- scoreboard / reference model ----------------
  // Pending requests live in a queue of {addr, data}; outputs are derived
  // from the rules: pop oldest when non-empty and not stalled, push when
  // fewer than two are pending.
  logic [W+D-1:0] exp_q[$];
  logic [N-1:0]   exp_we;
  logic [D-1:0]   exp_wdata;
  int             exp_drop;
  int             exp_wr;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_we    = '0;
    exp_wdata = '0;
    exp_drop  = 0;
    exp_wr    = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] a,
                            input logic [D-1:0] d, input logic s);
    logic           do_pop, do_push;
    logic [W+D-1:0] e;
    do_pop  = (exp_q.size() > 0) && !s;
    do_push = v && (exp_q.size() < 2);
    exp_we  = '0;
    if (do_pop) begin
      e = exp_q.pop_front();
      if (e[W+D-1:D] != 0) begin
        exp_we    = '0;
        exp_we[e[W+D-1:D]] = 1'b1;
        exp_wdata = e[D-1:0];
        exp_wr    = (exp_wr + 1) % 65536;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
    if (do_push) exp_q.push_back({a, d});
  endtask

  task automatic check_all();
    check("we_out",    64'(we_out),     64'(exp_we));
    check("wdata_out", 64'(wdata_out),  64'(exp_wdata));
    check("drop_cnt",  64'(drop_cnt),   64'(exp_drop));
    check("wr_cnt",    64'(wr_cnt),     64'(exp_wr));
    check("in_ready",  64'(in_ready),   64'(exp_q.size() < 2));
    check("fsm",       64'(fsm_active), 64'(exp_q.size() != 0));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [W-1:0] a,
                       input logic [D-1:0] d, input logic s);
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    stall    = s;
    @(posedge clk);
    model_step(v, a, d, s);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(in_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    apply_reset();
    check("rst_we",  64'(we_out), 64'd0);
    check("rst_cnt", 64'(wr_cnt), 64'd0);

    // single write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    check("lat_none", 64'(we_out), 64'd0);
    cycle(1'b0, '0, '0, 1'b0);
    check("single_we",    64'(we_out),    64'h20);
    check("single_wdata", 64'(wdata_out), 64'hDEADBEEF);
    check("single_wr",    64'(wr_cnt),    64'd1);
    idle(1);
    check("single_pulse", 64'(we_out), 64'd0);

    // register 0 drop
    cycle(1'b1, 5'd0, 32'h1234, 1'b0);
    idle(2);
    check("drop_cnt1",   64'(drop_cnt),  64'd1);
    check("drop_wr",     64'(wr_cnt),    64'd1);
    check("drop_wdata",  64'(wdata_out), 64'hDEADBEEF);

    // full / stall
    cycle(1'b1, 5'd3, 32'h33, 1'b1);
    cycle(1'b1, 5'd7, 32'h77, 1'b1);
    check("full_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 5'd9, 32'h99, 1'b1);
    cycle(1'b0, '0, '0, 1'b0);
    check("stall_we3", 64'(we_out), 64'h08);
    cycle(1'b0, '0, '0, 1'b0);
    check("stall_we7", 64'(we_out), 64'h80);
    idle(2);
    check("no_we9", 64'(we_out), 64'd0);

    // back-to-back 1..31
    for (int a = 1; a < 32; a++) begin
      cycle(1'b1, W'(a), $urandom, 1'b0);
      check("b2b_ready", 64'(in_ready), 64'd1);
    end
    idle(2);

    // reset mid-operation with two entries pending
    cycle(1'b1, 5'd4, 32'hA, 1'b1);
    cycle(1'b1, 5'd6, 32'hB, 1'b1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_we",    64'(we_out),    64'd0);
    check("mid_rst_wdata", 64'(wdata_out), 64'd0);
    check("mid_rst_wr",    64'(wr_cnt),    64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'd1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b0);
      check("post_rst_we", 64'(we_out), 64'd0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, N-1)),
            $urandom, 1'($urandom_range(0, 3) == 0));
    idle(3);

    // drop counter saturation
    apply_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 5'd0, $urandom, 1'b0);
    idle(2);
    check("drop_sat", 64'(drop_cnt), 64'd255);

    // write counter wrap
    apply_reset();
    for (int i = 0; i < 65536; i++)
      cycle(1'b1, W'($urandom_range(1, N-1)), $urandom, 1'b0);
    idle(2);
    check("wr_wrap", 64'(wr_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_decoder.md
REGFILE_WB_DECODER -- requirements
Module: regfile_wb_decoder

Interface
REQ-001 The module SHALL have parameter W, default 5, which is the register address width.
REQ-002 The module SHALL have parameter D, default 32, which is the write-data width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: a write-back request is present.
REQ-006 The module SHALL have port in_addr, input, W bits: the destination register index.
REQ-007 The module SHALL have port in_data, input, D bits: the write-back data.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-009 The module SHALL have port stall, input, 1 bit: when high, no entry is popped.
REQ-010 The module SHALL have port we_out, output, 2**W bits: one-hot per-register write enable.
REQ-011 The module SHALL have port wdata_out, output, D bits: data accompanying we_out.
REQ-012 The module SHALL have port drop_cnt, output, 8 bits: count of dropped writes to register 0.
REQ-013 The module SHALL have port wr_cnt, output, 16 bits: count of performed register writes.

Function
REQ-014 The block SHALL hold a 2-entry FIFO of {addr, data} pairs, with occupancy in the range 0..2.
REQ-015 in_ready SHALL equal (occupancy < 2) and SHALL depend only on registered state.
REQ-016 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; data presented when in_ready=0 SHALL be ignored.
REQ-017 A pop SHALL occur on a rising edge where occupancy>0 and stall=0; it SHALL pop the oldest entry only.
REQ-018 A push and a pop on the same edge SHALL both take effect, with occupancy unchanged.
REQ-019 If the FIFO is empty, the same-edge request SHALL NOT be popped; there SHALL be no bypass.
REQ-020 On a pop of a nonzero address a, we_out SHALL become the one-hot value with only bit a set, for exactly one cycle after the edge.
REQ-021 On a pop of a nonzero address, wdata_out SHALL take the popped data, and wr_cnt SHALL increment by 1, wrapping modulo 2**16.
REQ-022 On a pop of address 0, we_out SHALL be all zeros and wdata_out SHALL hold its previous value.
REQ-023 On a pop of address 0, drop_cnt SHALL increment, saturating at 255.
REQ-024 In any cycle without a pop, we_out SHALL be all zeros and wdata_out SHALL hold its value.
REQ-025 Latency SHALL be as follows: a request pushed at edge k into an empty FIFO with stall=0 SHALL drive we_out in the cycle after edge k+1.
REQ-026 Sustained throughput SHALL be one write per cycle.
REQ-027 The two-state control SHALL be EMPTY (occupancy 0) and ACTIVE (occupancy 1..2).
REQ-028 The FSM SHALL move EMPTY->ACTIVE on a push, and ACTIVE->EMPTY on a pop with no push when occupancy=1.
REQ-029 Entries SHALL be read out in strict FIFO order, and the read and write pointers SHALL wrap modulo 2.
REQ-030 Asserting stall while an entry is pending SHALL retain FIFO contents; we_out SHALL go to zero on the next edge.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately, without waiting for clk, set occupancy to 0, pointers to 0, the FSM to EMPTY, we_out to 0, wdata_out to 0, drop_cnt to 0, and wr_cnt to 0.
REQ-032 A reset during operation SHALL discard all pending entries, with no write enable issued for them.
REQ-033 After rst_n deasserts, in_ready SHALL read 1 in the first cycle.

Verification
REQ-034 Single write: after reset, push addr=5 data=0xDEADBEEF with stall=0 -> in the cycle after the following edge, we_out=0x00000020 and wdata_out=0xDEADBEEF for one cycle; wr_cnt=1.
REQ-035 Register 0 drop: push addr=0 data=0x1234 -> we_out stays 0 and wdata_out is unchanged; drop_cnt=1, wr_cnt unchanged.
REQ-036 Full/stall: with stall=1, push addr=3 and then addr=7 -> in_ready=0. A third request with addr=9 is ignored. On release of stall -> we_out=0x08 and then 0x80 on consecutive cycles. addr 9 is never written.
REQ-037 Simultaneous push/pop: feed addr=1..31 back-to-back with stall=0 -> one one-hot output per cycle, in order; wr_cnt=31; occupancy never exceeds 1.
REQ-038 Reset mid-operation: with 2 entries pending under stall, pulse rst_n low between clock edges -> outputs go to 0 immediately; after release and stall=0, no write enables appear.
REQ-039 Counter limits: 300 writes to register 0 -> drop_cnt=255. wr_cnt preloaded by 65536 writes -> wr_cnt wraps to 0.
